// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared types and constants for the instruction-memory loader.
//   state_e        : loader FSM states
//   IMG_HDR_BYTES  : bytes in the image length header (big-endian word count)
//   BYTES_PER_WORD : image bytes packed into one instruction word
package im_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR_HI  = 3'd1,
    S_HDR_LO  = 3'd2,
    S_COLLECT = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  localparam int IMG_HDR_BYTES  = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/im_loader_word_assembler.sv
// word_assembler: packs image bytes into a big-endian 32-bit word.
//   clk, rst        : clock, async active-low reset
//   clr             : restart packing (new load)
//   shift_en        : accept data_in into the word buffer
//   data_in  [7:0]  : image byte
//   word     [31:0] : packed word, first byte of the word in [31:24]
//   word_full       : buffer already holds 3 bytes, the next shift completes a word
module word_assembler
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  data_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (clr) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (shift_en) begin
      // Shifting left puts the earliest byte of the word at the top.
      word_q <= {word_q[23:0], data_in};
      idx_q  <= idx_q + 2'd1;
    end
  end

  assign word      = word_q;
  assign word_full = (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/im_loader.sv
// im_loader: boot-time loader that streams a length-prefixed image into the
// instruction memory and holds the core in reset until the image is written.
//   clk, rst           : clock, async active-low reset
//   start              : begin a load (honoured in IDLE or DONE only)
//   in_data/in_valid   : image byte stream; in_ready is the accept side
//   im_we/im_addr/im_wdata : instruction memory write port
//   cpu_rst            : core reset, high unless the image is complete
//   busy/done          : load in progress / image complete
//   ovf                : header word count exceeded memory depth (sticky per load)
//   word_cnt           : words consumed in the current load
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | after reset, waiting for start, core held in reset
// S_HDR_HI  | waiting for word count high byte
// S_HDR_LO  | waiting for word count low byte
// S_COLLECT | packing image bytes into the current word
// S_WRITE   | one-cycle memory write of the completed word
// S_DONE    | image loaded, core released, start reloads
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [15:0]       word_cnt
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  state_e      state_q;
  logic [15:0] n_q;
  logic [15:0] word_cnt_q;
  logic        ovf_q;

  logic        can_start;
  logic        xfer;
  logic        asm_shift;
  logic        word_full;
  logic [31:0] asm_word;
  logic [15:0] n_full;
  logic [15:0] word_cnt_inc;

  assign can_start    = start && (state_q == S_IDLE || state_q == S_DONE);
  assign xfer         = in_valid && in_ready;
  assign asm_shift    = xfer && (state_q == S_COLLECT);
  assign n_full       = {n_q[15:8], in_data};
  assign word_cnt_inc = word_cnt_q + 16'd1;

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (can_start),
    .shift_en  (asm_shift),
    .data_in   (in_data),
    .word      (asm_word),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      word_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_HDR_HI;
            n_q        <= '0;
            word_cnt_q <= '0;
            ovf_q      <= 1'b0;
          end
        end
        S_HDR_HI: begin
          if (xfer) begin
            n_q[15:8] <= in_data;
            state_q   <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (xfer) begin
            n_q[7:0] <= in_data;
            ovf_q    <= (32'(n_full) > DEPTH);
            state_q  <= (n_full == 16'd0) ? S_DONE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (xfer && word_full) state_q <= S_WRITE;
        end
        S_WRITE: begin
          word_cnt_q <= word_cnt_inc;
          state_q    <= (word_cnt_inc == n_q) ? S_DONE : S_COLLECT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // All strobes decode from registered state; nothing here sees in_valid or start.
  assign in_ready = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                    (state_q == S_COLLECT);
  // Words past the end of memory are still consumed but never written.
  assign im_we    = (state_q == S_WRITE) && (32'(word_cnt_q) < DEPTH);
  assign im_addr  = word_cnt_q[ADDR_W-1:0];
  assign im_wdata = asm_word;
  assign cpu_rst  = (state_q != S_DONE);
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign ovf      = ovf_q;
  assign word_cnt = word_cnt_q;

endmodule
